pwm_duty_meas: RTL and testbench

//   Receive-side counterpart of the 11-bit PWM generator. Samples an incoming PWM line and

---
 rtl/ebike_pwm_pkg.sv | 22 ++
 rtl/pwm_in_sync.sv | 37 +++
 rtl/pwm_duty_meas.sv | 174 +++++++++++++++++
 tb/tb_pwm_duty_meas.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/ebike_pwm_pkg.sv
// Shared definitions for the e-bike PWM receive path.
//   PWM_PERIOD  : nominal PWM period in clk cycles (generator side is 11-bit)
//   PWM_TIMEOUT : cycles without a qualifying edge before the line is declared stuck
//   DUTY_W      : width of the recovered duty word
//   pwm_meas_state_t : measurement FSM states
package ebike_pwm_pkg;

  localparam int PWM_PERIOD  = 2048;
  localparam int PWM_TIMEOUT = 4096;
  localparam int DUTY_W      = 11;

  localparam logic [DUTY_W-1:0] DUTY_MAX = '1;

  typedef enum logic [2:0] {
    SYNC     = 3'd0,
    MEAS_HI  = 3'd1,
    MEAS_LO  = 3'd2,
    STUCK_HI = 3'd3,
    STUCK_LO = 3'd4
  } pwm_meas_state_t;

endpackage

// File: rtl/pwm_in_sync.sv
// Two-flop synchronizer for the asynchronous PWM line plus edge detection.
//   clk    in  system clock
//   rst_n  in  synchronous active-low reset (clears all three flops)
//   pwm_in in  raw PWM line, asynchronous to clk
//   pwm_s  out synchronized line
//   rise   out 1-cycle pulse, pwm_s went 0->1 this cycle
//   fall   out 1-cycle pulse, pwm_s went 1->0 this cycle
module pwm_in_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pwm_in,
  output logic pwm_s,
  output logic rise,
  output logic fall
);

  logic sync1;
  logic pwm_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      pwm_s <= 1'b0;
      pwm_d <= 1'b0;
    end else begin
      sync1 <= pwm_in;
      pwm_s <= sync1;
      pwm_d <= pwm_s;
    end
  end

  // Edges are taken after the synchronizer, so a single-cycle pulse from a
  // same-clock source still produces one rise and one fall.
  assign rise = pwm_s & ~pwm_d;
  assign fall = ~pwm_s & pwm_d;

endmodule

// File: rtl/pwm_duty_meas.sv
// PWM duty measurement: recovers the duty word (high time - 1) of an incoming
// PWM line, flags off-nominal periods and detects stuck-high / stuck-low lines.
//   clk        in  system clock
//   rst_n      in  synchronous active-low reset
//   pwm_in     in  PWM line, asynchronous to clk
//   duty       out last recovered duty word
//   duty_vld   out one-cycle pulse when duty/period_err/sig_lost were updated
//   period_err out last measured period differed from PERIOD
//   sig_lost   out line was stuck low for TIMEOUT cycles
//   state_dbg  out current measurement FSM state
// Output protocol: duty_vld is a pure strobe with no ready/back-pressure; the
// consumer must capture duty, period_err and sig_lost in the cycle duty_vld is
// high. Those three outputs hold their value until the next strobe.
module pwm_duty_meas
  import ebike_pwm_pkg::*;
#(
  parameter int PERIOD  = PWM_PERIOD,
  parameter int TIMEOUT = PWM_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwm_in,
  output logic [DUTY_W-1:0] duty,
  output logic              duty_vld,
  output logic              period_err,
  output logic              sig_lost,
  output pwm_meas_state_t   state_dbg
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] PER_NOM  = CNT_W'(PERIOD);
  localparam logic [CNT_W-1:0] HI_LIMIT = CNT_W'(2 ** DUTY_W);

  logic pwm_s;
  logic rise;
  logic fall;

  pwm_in_sync u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .pwm_in(pwm_in),
    .pwm_s (pwm_s),
    .rise  (rise),
    .fall  (fall)
  );

  pwm_meas_state_t state;
  pwm_meas_state_t state_next;

  logic [CNT_W-1:0]  per_cnt;
  logic [CNT_W-1:0]  hi_cnt;
  logic [DUTY_W-1:0] hi_duty;
  logic              timeout;
  logic              per_load;
  logic              per_clear;
  logic              emit;
  logic [DUTY_W-1:0] emit_duty;
  logic              emit_perr;
  logic              emit_lost;

  // A high time longer than the duty word can express clamps to full scale.
  assign hi_duty = (hi_cnt > HI_LIMIT) ? DUTY_MAX : DUTY_W'(hi_cnt - CNT_W'(1));

  always_comb begin
    state_next = state;
    emit       = 1'b0;
    emit_duty  = '0;
    emit_perr  = 1'b0;
    emit_lost  = 1'b0;
    per_load   = rise;
    per_clear  = 1'b0;
    // A rise in the same cycle always beats the timeout.
    timeout    = (per_cnt == CNT_MAX) && !rise;

    case (state)
      SYNC, MEAS_HI, MEAS_LO: begin
        if (timeout) begin
          // Reload to 1 so a stuck-high line re-emits exactly every TIMEOUT cycles.
          per_load = 1'b1;
          emit     = 1'b1;
          if (pwm_s) begin
            state_next = STUCK_HI;
            emit_duty  = DUTY_MAX;
          end else begin
            state_next = STUCK_LO;
            emit_lost  = 1'b1;
          end
        end else if (rise) begin
          // From SYNC the period before this rise was partial and is dropped.
          state_next = MEAS_HI;
          if (state == MEAS_LO) begin
            emit      = 1'b1;
            emit_duty = hi_duty;
            emit_perr = (per_cnt != PER_NOM);
          end
        end else if (fall && (state == MEAS_HI)) begin
          state_next = MEAS_LO;
        end
      end

      STUCK_HI: begin
        if (fall) begin
          state_next = SYNC;
          per_clear  = 1'b1;
        end else if (per_cnt == CNT_MAX) begin
          emit      = 1'b1;
          emit_duty = DUTY_MAX;
          per_load  = 1'b1;
        end
      end

      STUCK_LO: begin
        if (rise) begin
          state_next = MEAS_HI;
        end
      end

      default: begin
        state_next = SYNC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= SYNC;
    end else begin
      state <= state_next;
    end
  end

  // Both counters saturate at TIMEOUT and restart at 1 on a rise, so the
  // values seen at the next rise are the period and high time directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      per_cnt <= '0;
      hi_cnt  <= '0;
    end else begin
      if (per_clear) begin
        per_cnt <= '0;
      end else if (per_load) begin
        per_cnt <= CNT_W'(1);
      end else if (per_cnt != CNT_MAX) begin
        per_cnt <= per_cnt + CNT_W'(1);
      end

      if (rise) begin
        hi_cnt <= CNT_W'(1);
      end else if (pwm_s && (hi_cnt != CNT_MAX)) begin
        hi_cnt <= hi_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      duty       <= '0;
      duty_vld   <= 1'b0;
      period_err <= 1'b0;
      sig_lost   <= 1'b0;
    end else begin
      duty_vld <= emit;
      if (emit) begin
        duty       <= emit_duty;
        period_err <= emit_perr;
        sig_lost   <= emit_lost;
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_pwm_duty_meas.sv
// Self-checking bench for pwm_duty_meas.
module tb_pwm_duty_meas;
  import ebike_pwm_pkg::*;

  localparam int T   = PWM_TIMEOUT;
  localparam int P   = PWM_PERIOD;
  // Cycles from driving a rising edge on pwm_in to seeing duty_vld.
  localparam int LAT = 3;
  localparam int EW  = 32 + DUTY_W + 2;

  // ---------------- clock / reset / DUT ----------------
  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              pwm_in = 1'b0;
  logic [DUTY_W-1:0] duty;
  logic              duty_vld;
  logic              period_err;
  logic              sig_lost;
  pwm_meas_state_t   state_dbg;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  pwm_duty_meas dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pwm_in    (pwm_in),
    .duty      (duty),
    .duty_vld  (duty_vld),
    .period_err(period_err),
    .sig_lost  (sig_lost),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  // Expected emits: {cycle, duty, period_err, sig_lost}
  logic [EW-1:0] exp_q[$];

  // Reference model: an emit is produced at each rise that follows an
  // already-started measurement, from the previous rise's time and high time.
  bit armed;
  int prev_n;
  int prev_h;

  typedef struct {
    int high;
    int low;
    int exp_duty;
    bit exp_perr;
  } vec_t;
  vec_t vecs[6];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic int sat_duty(input int h);
    return (h - 1 > 2047) ? 2047 : h - 1;
  endfunction

  task automatic push_exp(input int c, input int d, input bit pe, input bit lo);
    exp_q.push_back({32'(c), DUTY_W'(d), pe, lo});
  endtask

  // ---------------- driver tasks (start and end on a negedge) ----------------
  task automatic drive(input bit v, input int n);
    for (int i = 0; i < n; i++) begin
      pwm_in = v;
      @(negedge clk);
    end
  endtask

  task automatic seg(input int h, input int l);
    if (armed) push_exp(cyc + LAT, sat_duty(prev_h), (cyc - prev_n) != P, 1'b0);
    armed  = 1'b1;
    prev_n = cyc;
    prev_h = h;
    drive(1'b1, h);
    drive(1'b0, l);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    armed = 1'b0;
    chk("reset_outputs", {duty, duty_vld, period_err, sig_lost}, 64'd0);
    chk("reset_state", state_dbg, SYNC);
  endtask

  task automatic phase_end(input string name);
    drive(1'b0, 8);
    chk(name, exp_q.size(), 0);
  endtask

  // ---------------- monitor ----------------
  logic [EW-1:0] got_r;
  logic [EW-1:0] want_r;

  always @(negedge clk) begin
    if (duty_vld === 1'b1) begin
      got_r = {32'(cyc), duty, period_err, sig_lost};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_vld: cycle=%0d duty=%0d perr=%0b lost=%0b, required no emit",
                 cyc, duty, period_err, sig_lost);
      end else begin
        want_r = exp_q.pop_front();
        if (got_r !== want_r) begin
          errors++;
          $display("FAIL emit: got cycle=%0d duty=%0d perr=%0b lost=%0b, required cycle=%0d duty=%0d perr=%0b lost=%0b",
                   cyc, duty, period_err, sig_lost,
                   want_r[EW-1:DUTY_W+2], want_r[DUTY_W+1:2], want_r[1], want_r[0]);
        end
      end
    end
    while (exp_q.size() > 0) begin
      want_r = exp_q[0];
      if (int'(want_r[EW-1:DUTY_W+2]) >= cyc) break;
      checks++;
      errors++;
      $display("FAIL missed_vld: no strobe, required cycle=%0d duty=%0d perr=%0b lost=%0b",
               want_r[EW-1:DUTY_W+2], want_r[DUTY_W+1:2], want_r[1], want_r[0]);
      void'(exp_q.pop_front());
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int n;
    int h;
    int l;
    int per;

    vecs[0] = '{high: 513,  low: 1535, exp_duty: 512,  exp_perr: 1'b0};
    vecs[1] = '{high: 1,    low: 2047, exp_duty: 0,    exp_perr: 1'b0};
    vecs[2] = '{high: 2047, low: 1,    exp_duty: 2046, exp_perr: 1'b0};
    vecs[3] = '{high: 300,  low: 1700, exp_duty: 299,  exp_perr: 1'b1};
    vecs[4] = '{high: 2500, low: 200,  exp_duty: 2047, exp_perr: 1'b1};
    vecs[5] = '{high: 1,    low: 1,    exp_duty: 0,    exp_perr: 1'b1};

    repeat (2) @(negedge clk);

    // Periodic waveforms from the table; the held outputs after the last
    // emit must match the hand-computed record.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      drive(1'b0, 10);
      seg(vecs[i].high, vecs[i].low);
      seg(vecs[i].high, vecs[i].low);
      seg(4, 10);
      chk($sformatf("vec%0d_hold", i), {duty, period_err, sig_lost},
          {DUTY_W'(vecs[i].exp_duty), vecs[i].exp_perr, 1'b0});
      phase_end($sformatf("vec%0d_drain", i));
    end

    // Line stuck high from reset: full-scale emits every TIMEOUT cycles,
    // then a fall returns to SYNC and the next first rise emits nothing.
    do_reset();
    n = cyc;
    push_exp(n + LAT + T, 2047, 1'b0, 1'b0);
    push_exp(n + LAT + 2 * T, 2047, 1'b0, 1'b0);
    drive(1'b1, 2 * T + 100);
    chk("stuck_hi_state", state_dbg, STUCK_HI);
    chk("stuck_hi_lost", sig_lost, 1'b0);
    armed = 1'b0;
    drive(1'b0, 30);
    seg(513, 1535);
    seg(4, 10);
    phase_end("stuck_hi_drain");

    // Line stuck low from reset: one lost emit, then recovery on duty 100.
    do_reset();
    n = cyc;
    push_exp(n + 1 + T, 0, 1'b0, 1'b1);
    drive(1'b0, T + 50);
    chk("stuck_lo_state", state_dbg, STUCK_LO);
    chk("stuck_lo_lost_held", sig_lost, 1'b1);
    seg(101, 1947);
    seg(101, 1947);
    chk("recover_lost_clear", {duty, sig_lost}, {DUTY_W'(100), 1'b0});
    seg(4, 10);
    phase_end("stuck_lo_drain");

    // Reset in the middle of the low phase aborts the measurement.
    do_reset();
    drive(1'b0, 10);
    seg(513, 1535);
    seg(513, 500);
    chk("pre_abort_duty", duty, DUTY_W'(512));
    chk("pre_abort_state", state_dbg, MEAS_LO);
    do_reset();
    drive(1'b0, 1035);
    seg(513, 1535);
    seg(4, 10);
    phase_end("abort_drain");

    // Off-nominal period then back to nominal, followed by random waveforms.
    do_reset();
    drive(1'b0, 10);
    seg(300, 1700);
    seg(513, 1535);
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        h = $urandom_range(1, P - 1);
        l = P - h;
      end else begin
        per = $urandom_range(2, 3000);
        h   = $urandom_range(1, per - 1);
        l   = per - h;
      end
      seg(h, l);
    end
    seg(4, 10);
    phase_end("random_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
